// File: rtl/vector_lsu_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vector_lsu_pkg;

  localparam int VLEN        = 2;
  localparam int ELEN        = 32;
  localparam int DATA_WIDTH  = VLEN * ELEN;
  localparam int ADDR_WIDTH  = 32;
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int LINE_BYTES  = 8;
  localparam int UNIT_STRIDE = 4;
  localparam int IDX_W       = (VLEN > 1) ? $clog2(VLEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic                  store;
    logic                  strided;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] stride;
    logic [4:0]            vd;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  // Clears the byte-within-line bits so the address names a whole DTIM line.
  function automatic logic [ADDR_WIDTH-1:0] lineAlign(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/vector_lsu_lane_mux.sv
// Per-element lane steering: picks the addressed 32-bit lane out of a line
// for loads, replicates a store element into both lanes and builds its strobe.
module vector_lsu_lane_mux
  import vector_lsu_pkg::*;
(
  input  logic                  i_lane,
  input  logic [ELEN-1:0]       i_elem,
  input  logic [DATA_WIDTH-1:0] i_line,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  output logic [ELEN-1:0]       o_elem
);

  localparam int ELEM_BYTES = ELEN / 8;

  assign o_wdata = {VLEN{i_elem}};
  assign o_wstrb = i_lane ? {{ELEM_BYTES{1'b1}}, {ELEM_BYTES{1'b0}}}
                          : {{ELEM_BYTES{1'b0}}, {ELEM_BYTES{1'b1}}};
  assign o_elem  = i_lane ? i_line[2*ELEN-1:ELEN] : i_line[ELEN-1:0];

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer: takes one vector memory op, issues either one
// full-line DTIM beat or one beat per element, and returns a single response.
module vector_lsu
  import vector_lsu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic                  io_req_bits_store,
  input  logic                  io_req_bits_strided,
  input  logic [ADDR_WIDTH-1:0] io_req_bits_base,
  input  logic [ADDR_WIDTH-1:0] io_req_bits_stride,
  input  logic [4:0]            io_req_bits_vd,
  input  logic [DATA_WIDTH-1:0] io_req_bits_wdata,
  output logic                  io_resp_valid,
  input  logic                  io_resp_ready,
  output logic [4:0]            io_resp_bits_vd,
  output logic                  io_resp_bits_store,
  output logic                  io_resp_bits_error,
  output logic [DATA_WIDTH-1:0] io_resp_bits_rdata,
  output logic                  io_mem_req_valid,
  input  logic                  io_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] io_mem_req_bits_addr,
  output logic                  io_mem_req_bits_write,
  output logic [DATA_WIDTH-1:0] io_mem_req_bits_wdata,
  output logic [STRB_WIDTH-1:0] io_mem_req_bits_wstrb,
  input  logic                  io_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] io_mem_resp_bits_rdata,
  output logic                  io_busy
);

  state_t                r_state;
  state_t                w_next;
  req_t                  r_req;
  logic                  r_fast;
  logic                  r_error;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_ea;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_fast_in;
  logic                  w_capture;
  logic                  w_last;
  logic                  w_resp_fire;
  logic [ADDR_WIDTH-1:0] w_stride;
  logic [DATA_WIDTH-1:0] w_lane_wdata;
  logic [STRB_WIDTH-1:0] w_lane_wstrb;
  logic [ELEN-1:0]       w_lane_elem;

  assign w_accept     = io_req_valid && (r_state == ST_IDLE);
  assign w_misaligned = (io_req_bits_base[1:0] != 2'b00) ||
                        (io_req_bits_strided && (io_req_bits_stride[1:0] != 2'b00));
  assign w_fast_in    = !io_req_bits_strided && (io_req_bits_base[2:0] == 3'b000);
  assign w_capture    = (r_state == ST_WAIT) && io_mem_resp_valid;
  assign w_last       = r_fast || (r_idx == IDX_W'(VLEN - 1));
  assign w_resp_fire  = (r_state == ST_RESP) && io_resp_ready;
  assign w_stride     = r_req.strided ? r_req.stride : ADDR_WIDTH'(UNIT_STRIDE);

  vector_lsu_lane_mux u_lane_mux (
    .i_lane  (r_ea[2]),
    .i_elem  (r_req.wdata[r_idx*ELEN +: ELEN]),
    .i_line  (io_mem_resp_bits_rdata),
    .o_wdata (w_lane_wdata),
    .o_wstrb (w_lane_wstrb),
    .o_elem  (w_lane_elem)
  );

  // State register; reset drops any op in flight straight back to idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs; a misaligned op skips memory entirely.
  always_comb begin
    w_next           = r_state;
    io_req_ready     = 1'b0;
    io_mem_req_valid = 1'b0;
    io_resp_valid    = 1'b0;
    io_busy          = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        io_req_ready = 1'b1;
        io_busy      = 1'b0;
        if (io_req_valid) w_next = w_misaligned ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        io_mem_req_valid = 1'b1;
        if (io_mem_req_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (io_mem_resp_valid) w_next = w_last ? ST_RESP : ST_REQ;
      end
      ST_RESP: begin
        io_resp_valid = 1'b1;
        if (io_resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, element walk and load-data assembly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req   <= '0;
      r_fast  <= 1'b0;
      r_error <= 1'b0;
      r_idx   <= '0;
      r_ea    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_req.store   <= io_req_bits_store;
        r_req.strided <= io_req_bits_strided;
        r_req.base    <= io_req_bits_base;
        r_req.stride  <= io_req_bits_stride;
        r_req.vd      <= io_req_bits_vd;
        r_req.wdata   <= io_req_bits_wdata;
        r_fast        <= w_fast_in;
        r_error       <= w_misaligned;
        r_idx         <= '0;
        r_ea          <= io_req_bits_base;
        r_rdata       <= '0;
      end
      if (w_capture) begin
        if (!r_req.store) begin
          if (r_fast) r_rdata <= io_mem_resp_bits_rdata;
          else        r_rdata[r_idx*ELEN +: ELEN] <= w_lane_elem;
        end
        if (!w_last) begin
          r_idx <= r_idx + IDX_W'(1);
          r_ea  <= r_ea + w_stride;
        end
      end
      if (w_resp_fire) r_rdata <= '0;
    end
  end

  assign io_mem_req_bits_addr  = r_fast ? r_req.base : lineAlign(r_ea);
  assign io_mem_req_bits_write = r_req.store;
  assign io_mem_req_bits_wdata = r_fast ? r_req.wdata : w_lane_wdata;
  assign io_mem_req_bits_wstrb = !r_req.store ? '0 : (r_fast ? '1 : w_lane_wstrb);

  assign io_resp_bits_vd    = r_req.vd;
  assign io_resp_bits_store = r_req.store;
  assign io_resp_bits_error = r_error;
  assign io_resp_bits_rdata = r_rdata;

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: directed test-plan cases followed by
// randomized ops checked against a word-level memory model.
module tb_vector_lsu;
  import vector_lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic        io_req_bits_store = 1'b0;
  logic        io_req_bits_strided = 1'b0;
  logic [31:0] io_req_bits_base = '0;
  logic [31:0] io_req_bits_stride = '0;
  logic [4:0]  io_req_bits_vd = '0;
  logic [63:0] io_req_bits_wdata = '0;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b0;
  logic [4:0]  io_resp_bits_vd;
  logic        io_resp_bits_store;
  logic        io_resp_bits_error;
  logic [63:0] io_resp_bits_rdata;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready = 1'b1;
  logic [31:0] io_mem_req_bits_addr;
  logic        io_mem_req_bits_write;
  logic [63:0] io_mem_req_bits_wdata;
  logic [7:0]  io_mem_req_bits_wstrb;
  logic        io_mem_resp_valid = 1'b0;
  logic [63:0] io_mem_resp_bits_rdata = '0;
  logic        io_busy;

  vector_lsu dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_req_valid           (io_req_valid),
    .io_req_ready           (io_req_ready),
    .io_req_bits_store      (io_req_bits_store),
    .io_req_bits_strided    (io_req_bits_strided),
    .io_req_bits_base       (io_req_bits_base),
    .io_req_bits_stride     (io_req_bits_stride),
    .io_req_bits_vd         (io_req_bits_vd),
    .io_req_bits_wdata      (io_req_bits_wdata),
    .io_resp_valid          (io_resp_valid),
    .io_resp_ready          (io_resp_ready),
    .io_resp_bits_vd        (io_resp_bits_vd),
    .io_resp_bits_store     (io_resp_bits_store),
    .io_resp_bits_error     (io_resp_bits_error),
    .io_resp_bits_rdata     (io_resp_bits_rdata),
    .io_mem_req_valid       (io_mem_req_valid),
    .io_mem_req_ready       (io_mem_req_ready),
    .io_mem_req_bits_addr   (io_mem_req_bits_addr),
    .io_mem_req_bits_write  (io_mem_req_bits_write),
    .io_mem_req_bits_wdata  (io_mem_req_bits_wdata),
    .io_mem_req_bits_wstrb  (io_mem_req_bits_wstrb),
    .io_mem_resp_valid      (io_mem_resp_valid),
    .io_mem_resp_bits_rdata (io_mem_resp_bits_rdata),
    .io_busy                (io_busy)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;

  // DTIM model state
  logic [63:0] tbMem [logic [31:0]];
  int          respQ_due[$];
  logic [63:0] respQ_data[$];
  bit          memRandom = 1'b0;
  int          fixedLatency = 1;
  int          beatCount = 0;
  int          badAddrCount = 0;
  logic [31:0] lastAddr = '0;
  logic [7:0]  lastWstrb = '0;
  int          lastDue = 0;

  // Reference model state: one 32-bit word per word address
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] expAddrQ[$];

  // Observations from the most recent op
  logic [63:0] obsRdata;
  logic        obsErr, obsStore;
  logic [4:0]  obsVd;
  int          obsLatency;
  bit          gotResp, stableOk;

  // Cycle counter, read by the stimulus only at falling edges.
  always @(posedge clock) cycleCount++;

  function automatic logic [63:0] tbRead(input logic [31:0] a);
    return tbMem.exists(a) ? tbMem[a] : 64'd0;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 32'd0;
  endfunction

  function automatic logic [31:0] tbWord(input logic [31:0] a);
    logic [63:0] line;
    line = tbRead({a[31:3], 3'b000});
    return a[2] ? line[63:32] : line[31:0];
  endfunction

  task automatic setLine(input logic [31:0] a, input logic [63:0] v);
    tbMem[a]       = v;
    refMem[a]      = v[31:0];
    refMem[a + 4]  = v[63:32];
  endtask

  // DTIM responder: in-order, one response per request, latency >= 1.
  always @(negedge clock) begin
    logic [63:0] line;
    int          due;
    io_mem_resp_valid = 1'b0;
    io_mem_resp_bits_rdata = {$urandom, $urandom};
    if (respQ_due.size() > 0 && respQ_due[0] <= cycleCount) begin
      io_mem_resp_valid = 1'b1;
      io_mem_resp_bits_rdata = respQ_data.pop_front();
      void'(respQ_due.pop_front());
    end
    io_mem_req_ready = memRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (io_mem_req_valid && io_mem_req_ready) begin
      beatCount++;
      lastAddr  = io_mem_req_bits_addr;
      lastWstrb = io_mem_req_bits_wstrb;
      if (io_mem_req_bits_addr[2:0] != 3'b000) badAddrCount++;
      line = tbRead(io_mem_req_bits_addr);
      respQ_data.push_back(line);
      if (io_mem_req_bits_write) begin
        for (int b = 0; b < 8; b++)
          if (io_mem_req_bits_wstrb[b]) line[b*8 +: 8] = io_mem_req_bits_wdata[b*8 +: 8];
        tbMem[io_mem_req_bits_addr] = line;
      end
      due = cycleCount + (memRandom ? int'($urandom_range(1, 3)) : fixedLatency);
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      respQ_due.push_back(due);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural model: walk the elements with plain address arithmetic.
  task automatic modelOp(input logic st, input logic strided, input logic [31:0] base,
                         input logic [31:0] stride, input logic [63:0] wdata,
                         output logic [63:0] expRdata, output logic expErr, output int expBeats);
    logic [31:0] step, ea;
    expRdata = '0;
    expAddrQ.delete();
    expErr = (base[1:0] != 2'b00) || (strided && stride[1:0] != 2'b00);
    expBeats = 0;
    if (expErr) return;
    step = strided ? stride : 32'd4;
    expBeats = (!strided && base[2:0] == 3'b000) ? 1 : VLEN;
    for (int i = 0; i < VLEN; i++) begin
      ea = base + i * step;
      expAddrQ.push_back(ea);
      if (st) refMem[ea] = wdata[i*32 +: 32];
      else    expRdata[i*32 +: 32] = refRead(ea);
    end
  endtask

  // Issues one op and waits (bounded) for its response, holding resp_ready low.
  task automatic applyStimulus(input logic st, input logic strided, input logic [31:0] base,
                               input logic [31:0] stride, input logic [4:0] vd,
                               input logic [63:0] wdata, input int holdCycles);
    int          waitCount;
    int          tAccept;
    logic [71:0] snap;
    beatCount  = 0;
    gotResp    = 1'b0;
    stableOk   = 1'b1;
    obsLatency = -1;
    waitCount  = 0;
    while (!io_req_ready && waitCount < 50) begin
      @(negedge clock);
      waitCount++;
    end
    io_req_valid        = 1'b1;
    io_req_bits_store   = st;
    io_req_bits_strided = strided;
    io_req_bits_base    = base;
    io_req_bits_stride  = stride;
    io_req_bits_vd      = vd;
    io_req_bits_wdata   = wdata;
    tAccept = cycleCount;
    @(negedge clock);
    io_req_valid = 1'b0;
    waitCount = 0;
    while (!io_resp_valid && waitCount < 300) begin
      @(negedge clock);
      waitCount++;
    end
    if (!io_resp_valid) begin
      checkOutput("resp_timeout", {63'd0, io_resp_valid}, 64'd1);
      return;
    end
    gotResp    = 1'b1;
    obsLatency = cycleCount - tAccept;
    obsRdata   = io_resp_bits_rdata;
    obsErr     = io_resp_bits_error;
    obsStore   = io_resp_bits_store;
    obsVd      = io_resp_bits_vd;
    snap = {io_resp_valid, io_resp_bits_vd, io_resp_bits_store, io_resp_bits_error, io_resp_bits_rdata};
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clock);
      if ({io_resp_valid, io_resp_bits_vd, io_resp_bits_store, io_resp_bits_error,
           io_resp_bits_rdata} !== snap) stableOk = 1'b0;
    end
    io_resp_ready = 1'b1;
    @(negedge clock);
    io_resp_ready = 1'b0;
  endtask

  logic [63:0] expRdata;
  logic        expErr;
  int          expBeats;

  initial begin
    logic        rSt, rStrided;
    logic [31:0] rBase, rStride;
    logic [4:0]  rVd;
    logic [63:0] rWdata;
    int          k;
    bit          sawResp;
    int          waitCount;

    for (int a = 32'h0800_0000; a < 32'h0800_0800; a += 8)
      setLine(32'(a), {$urandom, $urandom});

    // Reset values
    repeat (3) @(negedge clock);
    checkOutput("rst_req_ready", {63'd0, io_req_ready}, 64'd1);
    checkOutput("rst_resp_valid", {63'd0, io_resp_valid}, 64'd0);
    checkOutput("rst_mem_req_valid", {63'd0, io_mem_req_valid}, 64'd0);
    checkOutput("rst_busy", {63'd0, io_busy}, 64'd0);
    checkOutput("rst_error_store", {62'd0, io_resp_bits_error, io_resp_bits_store}, 64'd0);
    checkOutput("rst_rdata", io_resp_bits_rdata, 64'd0);
    checkOutput("rst_mem_addr", {32'd0, io_mem_req_bits_addr}, 64'd0);
    checkOutput("rst_mem_wdata", io_mem_req_bits_wdata, 64'd0);
    checkOutput("rst_mem_wstrb_write", {55'd0, io_mem_req_bits_wstrb, io_mem_req_bits_write}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Unit-stride load, aligned line
    setLine(32'h0800_0100, 64'hdeadbeef_cafef00d);
    modelOp(1'b0, 1'b0, 32'h0800_0100, 32'd0, 64'd0, expRdata, expErr, expBeats);
    applyStimulus(1'b0, 1'b0, 32'h0800_0100, 32'd0, 5'd7, 64'd0, 0);
    checkOutput("uload_rdata", obsRdata, 64'hdeadbeef_cafef00d);
    checkOutput("uload_model", obsRdata, expRdata);
    checkOutput("uload_vd", {59'd0, obsVd}, 64'd7);
    checkOutput("uload_latency", 64'(obsLatency), 64'd3);
    checkOutput("uload_beats", 64'(beatCount), 64'd1);
    checkOutput("uload_addr", {32'd0, lastAddr}, 64'h0800_0100);

    // Unit-stride store, aligned line
    modelOp(1'b1, 1'b0, 32'h0800_0100, 32'd0, 64'h12345671_12345670, expRdata, expErr, expBeats);
    applyStimulus(1'b1, 1'b0, 32'h0800_0100, 32'd0, 5'd3, 64'h12345671_12345670, 0);
    checkOutput("ustore_rdata", obsRdata, 64'd0);
    checkOutput("ustore_store", {63'd0, obsStore}, 64'd1);
    checkOutput("ustore_beats", 64'(beatCount), 64'd1);
    checkOutput("ustore_wstrb", {56'd0, lastWstrb}, 64'hFF);
    checkOutput("ustore_line", tbRead(32'h0800_0100), 64'h12345671_12345670);
    checkOutput("ustore_latency", 64'(obsLatency), 64'd3);

    // Strided load, one element per line, upper lane
    setLine(32'h0800_0100, 64'hAAAAAAAA_11111111);
    setLine(32'h0800_0108, 64'hBBBBBBBB_22222222);
    modelOp(1'b0, 1'b1, 32'h0800_0104, 32'd8, 64'd0, expRdata, expErr, expBeats);
    applyStimulus(1'b0, 1'b1, 32'h0800_0104, 32'd8, 5'd12, 64'd0, 0);
    checkOutput("sload_rdata", obsRdata, 64'hBBBBBBBB_AAAAAAAA);
    checkOutput("sload_model", obsRdata, expRdata);
    checkOutput("sload_latency", 64'(obsLatency), 64'd5);
    checkOutput("sload_beats", 64'(beatCount), 64'd2);
    checkOutput("sload_last_addr", {32'd0, lastAddr}, 64'h0800_0108);

    // Zero-stride store: both elements hit lane 0, the second one wins
    modelOp(1'b1, 1'b1, 32'h0800_0100, 32'd0, 64'h00000002_00000001, expRdata, expErr, expBeats);
    applyStimulus(1'b1, 1'b1, 32'h0800_0100, 32'd0, 5'd1, 64'h00000002_00000001, 0);
    checkOutput("zstore_beats", 64'(beatCount), 64'd2);
    checkOutput("zstore_wstrb", {56'd0, lastWstrb}, 64'h0F);
    checkOutput("zstore_addr", {32'd0, lastAddr}, 64'h0800_0100);
    checkOutput("zstore_line", tbRead(32'h0800_0100), 64'hAAAAAAAA_00000002);
    checkOutput("zstore_model", {32'd0, tbWord(32'h0800_0100)}, {32'd0, refRead(32'h0800_0100)});

    // Misaligned base: immediate error response, bits held while stalled
    applyStimulus(1'b0, 1'b0, 32'h0800_0102, 32'd0, 5'd9, 64'd0, 5);
    checkOutput("mis_error", {63'd0, obsErr}, 64'd1);
    checkOutput("mis_latency", 64'(obsLatency), 64'd1);
    checkOutput("mis_beats", 64'(beatCount), 64'd0);
    checkOutput("mis_rdata", obsRdata, 64'd0);
    checkOutput("mis_vd", {59'd0, obsVd}, 64'd9);
    checkOutput("mis_stable", {63'd0, stableOk}, 64'd1);

    // Reset while waiting on DTIM; the late response must be dropped
    fixedLatency = 6;
    beatCount = 0;
    io_req_valid        = 1'b1;
    io_req_bits_store   = 1'b0;
    io_req_bits_strided = 1'b0;
    io_req_bits_base    = 32'h0800_0108;
    io_req_bits_vd      = 5'd4;
    @(negedge clock);
    io_req_valid = 1'b0;
    waitCount = 0;
    while (beatCount == 0 && waitCount < 50) begin
      @(negedge clock);
      waitCount++;
    end
    checkOutput("rstmid_issued", 64'(beatCount), 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstmid_busy", {63'd0, io_busy}, 64'd0);
    checkOutput("rstmid_ready", {63'd0, io_req_ready}, 64'd1);
    reset = 1'b1;
    sawResp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (io_resp_valid || io_mem_req_valid) sawResp = 1'b1;
    end
    checkOutput("rstmid_no_resp", {63'd0, sawResp}, 64'd0);
    checkOutput("rstmid_drained", 64'(respQ_due.size()), 64'd0);
    fixedLatency = 1;
    modelOp(1'b0, 1'b0, 32'h0800_0108, 32'd0, 64'd0, expRdata, expErr, expBeats);
    applyStimulus(1'b0, 1'b0, 32'h0800_0108, 32'd0, 5'd4, 64'd0, 0);
    checkOutput("rstmid_next_rdata", obsRdata, 64'hBBBBBBBB_22222222);
    checkOutput("rstmid_next_vd", {59'd0, obsVd}, 64'd4);

    // Randomized ops against the reference model with a jittery DTIM
    memRandom = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rSt      = 1'($urandom_range(0, 1));
      rStrided = 1'($urandom_range(0, 1));
      rBase    = 32'h0800_0200 + 32'($urandom_range(0, 127)) * 4;
      if ($urandom_range(0, 7) == 0) rBase[1:0] = 2'($urandom_range(1, 3));
      k        = int'($urandom_range(0, 32)) - 16;
      rStride  = 32'(k * 4);
      if ($urandom_range(0, 7) == 0) rStride[1:0] = 2'($urandom_range(1, 3));
      rVd      = 5'($urandom);
      rWdata   = {$urandom, $urandom};
      modelOp(rSt, rStrided, rBase, rStride, rWdata, expRdata, expErr, expBeats);
      applyStimulus(rSt, rStrided, rBase, rStride, rVd, rWdata, int'($urandom_range(0, 2)));
      checkOutput($sformatf("rand%0d_rdata", n), obsRdata, expRdata);
      checkOutput($sformatf("rand%0d_error", n), {63'd0, obsErr}, {63'd0, expErr});
      checkOutput($sformatf("rand%0d_vd_store", n), {58'd0, obsVd, obsStore}, {58'd0, rVd, rSt});
      checkOutput($sformatf("rand%0d_beats", n), 64'(beatCount), 64'(expBeats));
      checkOutput($sformatf("rand%0d_stable", n), {63'd0, stableOk}, 64'd1);
      if (rSt && !expErr)
        foreach (expAddrQ[j])
          checkOutput($sformatf("rand%0d_mem%0d", n, j), {32'd0, tbWord(expAddrQ[j])},
                      {32'd0, refRead(expAddrQ[j])});
    end

    checkOutput("line_aligned_addrs", 64'(badAddrCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store sequencer between the tile core's vector execute stage and the data TIM port. Accepts one vector memory op at a time (unit-stride `vle32`/`vse32`, strided `vlse32`/`vsse32`). Issues either one full-width DTIM beat or VLEN per-element beats, assembles load data, and returns a single response for the vector register writeback.

## Interface
- `VLEN`, 2, elements per vector register
- `ELEN`, 32, element width in bits
- `DATA_WIDTH`, VLEN*ELEN, DTIM line width in bits (64)
- `ADDR_WIDTH`, 32, byte address width
- `clock` in 1: single clock; reset is asynchronous and active-low.
- `reset` in 1: active-low, asynchronous assert, synchronous deassert handled upstream.
- `io_req_valid` in 1 / `io_req_ready` out 1: op handshake.
- `io_req_bits_store` in 1: 1 = store, 0 = load.
- `io_req_bits_strided` in 1: 1 = use stride, 0 = unit stride (implied stride 4).
- `io_req_bits_base` in ADDR_WIDTH: byte base address from rs1.
- `io_req_bits_stride` in ADDR_WIDTH: byte stride from rs2, two's complement.
- `io_req_bits_vd` in 5: destination (load) or source (store) vreg index, echoed back.
- `io_req_bits_wdata` in DATA_WIDTH: store data; element i at bits [32i+31:32i].
- `io_resp_valid` out 1 / `io_resp_ready` in 1: completion handshake.
- `io_resp_bits_vd` out 5; `io_resp_bits_store` out 1; `io_resp_bits_error` out 1 (misaligned).
- `io_resp_bits_rdata` out DATA_WIDTH: assembled load data; 0 for stores and errors.
- `io_mem_req_valid` out 1 / `io_mem_req_ready` in 1: DTIM request handshake.
- `io_mem_req_bits_addr` out ADDR_WIDTH: line-aligned byte address (low 3 bits zero).
- `io_mem_req_bits_write` out 1; `io_mem_req_bits_wdata` out DATA_WIDTH; `io_mem_req_bits_wstrb` out DATA_WIDTH/8.
- `io_mem_resp_valid` in 1; `io_mem_resp_bits_rdata` in DATA_WIDTH: one response per request, in order, latency >= 1.
- `io_busy` out 1: high in any state except IDLE.

## Operation
- FSM: IDLE, REQ, WAIT, RESP. `io_req_ready` = (state == IDLE).
- Accept in IDLE: latch req fields. If base[1:0] != 0 or (strided and stride[1:0] != 0), go to RESP with error=1, no memory traffic.
- Fast path: not strided and base[2:0] == 0: one beat, addr = base, wstrb = 0xFF, full-line data.
- Element path (otherwise): element counter i = 0..VLEN-1; element address ea = base + i*stride (unit: stride 4), modulo 2^32. Beat addr = ea & ~7; lane = ea[2].
- Element store: wdata = element i replicated in both lanes; wstrb = 0x0F (lane 0) or 0xF0 (lane 1).
- Element load: element i of rdata buffer <= mem rdata lane `ea[2]`.
- REQ: `io_mem_req_valid`=1 until `io_mem_req_ready`, then WAIT. WAIT: on `io_mem_resp_valid` capture data. Then REQ if elements remain, else RESP.
- RESP: `io_resp_valid` held with stable bits until `io_resp_ready`, then IDLE; rdata buffer cleared on accept.
- Zero stride legal: every element reads/writes the same address; last store wins.
- `io_mem_resp_valid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `io_req_ready`=1; `io_resp_valid`, `io_mem_req_valid`, `io_busy`, error, store = 0; all data/address outputs 0.
- `io_mem_req_valid` asserts cycle after accept. Fast path with ready=1, 1-cycle memory: accept T, mem req T+1, mem resp T+2, `io_resp_valid` T+3.
- Element path adds 2 cycles per additional element (VLEN=2: `io_resp_valid` at T+5).
- Error path: `io_resp_valid` at T+1.
- Reset mid-op: immediate return to IDLE, outstanding DTIM response dropped, no partial response emitted.
- No back-to-back accept: next accept earliest cycle after resp handshake.

## Structure
- `vector_lsu_pkg`: state enum, request struct (store, strided, base, stride, vd, wdata), constants LINE_BYTES=8, UNIT_STRIDE=4.
- Sub-module `vector_lsu_lane_mux`: combinational lane select/replicate and wstrb generation from ea[2].

## Test plan
- Unit-stride load base 0x0800_0100, line = 0xdeadbeef_cafef00d -> single beat addr 0x0800_0100, rdata 0xdeadbeef_cafef00d, vd echoed.
- Unit-stride store base 0x0800_0100, wdata 0x12345671_12345670 -> one write, wstrb 0xFF, line holds wdata.
- Strided load base 0x0800_0104, stride 8; lines 0x100 = 0xAAAAAAAA_11111111, 0x108 = 0xBBBBBBBB_22222222 -> two beats, wstrb unused, rdata 0xBBBBBBBB_AAAAAAAA.
- Strided store base 0x0800_0100, stride 0, wdata 0x2_00000001 -> two writes to 0x100 lane 0 (wstrb 0x0F), final word 0x00000002.
- Misaligned base 0x0800_0102 -> no mem req, `io_resp_bits_error`=1 at T+1; `io_resp_ready` held low 5 cycles -> resp bits stable.
- Assert reset during WAIT, deliver late mem resp -> state IDLE, no `io_resp_valid`, next load completes correctly.
